// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words big-endian, one byte per clock, into the instruction memory write port.
// Define IMEM_LOADER_CHECKSUM_EN to build the running modulo-2^32 checksum of accepted words.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_word_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       checksum_o
);
  localparam int SW = ADDR_W + CNT_W + 2;
  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        wdata_q;
  logic              we_q, busy_q, done_q, err_q, err_d;
  logic [SW-1:0]     end_addr;
  logic              fits, start_ok, accept;
  // Range check is done wide enough that base + 4*count can never wrap.
  assign end_addr   = SW'(base_addr_i) + (SW'(word_count_i) << 2);
  assign fits       = (base_addr_i[1:0] == 2'b00) && (end_addr <= (SW'(1) << ADDR_W));
  assign start_ok   = (state_q == IDLE) && start_i && fits;
  assign in_ready_o = (state_q == WAIT_WORD) || ((state_q == WRITE) && (idx_q == 2'd3) && (rem_q != CNT_W'(1)));
  assign accept     = in_valid_i && in_ready_o;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = start_i && !fits;
        if (start_ok) begin
          addr_d  = base_addr_i;
          rem_d   = word_count_i;
          state_d = (word_count_i == '0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: if (accept) begin
        word_d  = in_word_i;
        idx_d   = 2'd0;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == 2'd3) begin
          rem_d   = rem_q - 1'b1;
          word_d  = accept ? in_word_i : word_q;
          state_d = (rem_q == CNT_W'(1)) ? DONE : accept ? WRITE : WAIT_WORD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      we_q    <= state_d == WRITE;
      wdata_q <= (state_d == WRITE) ? word_d[{~idx_d, 3'b000} +: 8] : wdata_q;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      err_q   <= err_d;
    end
  end
  // addr_q is the byte address of the write being presented while in WRITE.
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] chk_q, chk_d;
  assign chk_d = start_ok ? '0 : accept ? chk_q + in_word_i : chk_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= '0;
    else chk_q <= chk_d;
  end
  assign checksum_o = chk_q;
`else
  assign checksum_o = '0;
`endif
endmodule
